mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-memory bus. It answers the same address, write-data, write-enable and mode signals that the CPU drives into mem.
- Top-level decode routes accesses in the BASE_ADDR window here; read data is muxed back into the CPU's data_mem_IN.
- Bytes written by the CPU are queued in a FIFO and serialised as 8N1 frames on tx.

---
 rtl/mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ==========================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a byte TX FIFO
// Revision 1.0
// ==========================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  mode,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     period_q, period_d;
  logic [15:0]     tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            irq_q, irq_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [7:0]      mem_q [DEPTH];

  logic        wr_acc, empty, full, busy, tick_end, pop, push_req, push;
  logic [1:0]  sel;
  logic [31:0] count_ext, reg_val, rd_fmt;
  logic [3:0]  cnt_sat;
  logic        unused_ok;

  assign hit       = (a[31:4] == BASE_ADDR[31:4]);
  assign wr_acc    = we & hit;
  assign sel       = a[3:2];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign busy      = (state_q != S_IDLE);
  assign tick_end  = (tick_q == period_q);
  assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && tick_end));
  assign push_req  = wr_acc && (sel == 2'd0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);
  assign count_ext = 32'(count_q);
  assign cnt_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign unused_ok = ^{a[1], wd[31:16]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_acc && (sel == 2'd1) && wd[3]) ovf_d = 1'b0;
    if (push_req && !push) ovf_d = 1'b1;
    if (wr_acc && (sel == 2'd2)) begin
      if (mode[1:0] == 2'b00) begin
        if (a[0]) div_d[15:8] = wd[7:0];
        else      div_d[7:0]  = wd[7:0];
      end else begin
        div_d = wd[15:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    if (pop) begin
      state_d  = S_START;
      period_d = div_q;
      tick_d   = '0;
      shreg_d  = mem_q[rd_ptr_q];
      tx_d     = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (!tick_end) begin
        tick_d = tick_q + 1'b1;
      end else begin
        tick_d = '0;
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = 3'd0;
            tx_d    = shreg_q[0];
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_q >> 1;
              tx_d    = shreg_q[1];
            end
          end
          default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        endcase
      end
    end
    irq_d = (count_d == '0) && (state_d == S_IDLE);
  end

  always_comb begin
    reg_val = '0;
    case (sel)
      2'd1:    reg_val = {24'd0, cnt_sat, ovf_q, empty, full, busy};
      2'd2:    reg_val = {16'd0, div_q};
      default: reg_val = '0;
    endcase
    case (mode)
      3'b000:  rd_fmt = {{24{reg_val[7]}}, reg_val[7:0]};
      3'b001:  rd_fmt = {{16{reg_val[15]}}, reg_val[15:0]};
      3'b100:  rd_fmt = {24'd0, reg_val[7:0]};
      3'b101:  rd_fmt = {16'd0, reg_val[15:0]};
      default: rd_fmt = reg_val;
    endcase
    rd = hit ? rd_fmt : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wd[7:0];
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// tb_mmio_uart_tx : randomized self-checking bench; tx line is logged every
// cycle and compared against frames built from the queue of accepted bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic [2:0]  mode = 3'b010;
  logic [31:0] rd;
  logic        hit, tx, irq;

  int   checks = 0;
  int   errors = 0;
  logic rec_en = 1'b0;
  logic txlog [$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .mode(mode),
    .rd(rd), .hit(hit), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) txlog.push_back(tx);

  task automatic start_rec();
    txlog.delete();
    rec_en = 1'b1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] md);
    a = addr; wd = data; mode = md; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [2:0] md, output logic [31:0] v);
    a = addr; mode = md; we = 1'b0;
    #1;
    v = rd;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int first_zero();
    for (int i = 0; i < txlog.size(); i++) if (txlog[i] === 1'b0) return i;
    return -1;
  endfunction

  // Mismatching samples between the log and the ideal 8N1 waveform of the given frames.
  function automatic int wave_diff(input logic [7:0] bytes [$], input int divs [$]);
    int s, idx, errs;
    logic [9:0] fr;
    errs = 0;
    s = first_zero();
    if (bytes.size() == 0) begin
      for (int i = 0; i < txlog.size(); i++) if (txlog[i] !== 1'b1) errs++;
      return errs;
    end
    if (s < 0) return 100000;
    idx = s;
    for (int k = 0; k < bytes.size(); k++) begin
      fr = {1'b1, bytes[k], 1'b0};
      for (int j = 0; j < 10; j++)
        for (int c = 0; c <= divs[k]; c++) begin
          if (idx >= txlog.size() || txlog[idx] !== fr[j]) errs++;
          idx++;
        end
    end
    for (int i = idx; i < txlog.size(); i++) if (txlog[i] !== 1'b1) errs++;
    return errs;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b expected 1", irq); end
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h4); end
    bus_rd(A_DV, 3'b010, v);
    checks++;
    if (v !== 32'd867) begin errors++; $display("FAIL reset_div: got %0d expected 867", v); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    logic [7:0] bq [$];
    int dq [$];
    int busy_n, d;
    bus_wr(A_DV, 32'd3, 3'b010);
    start_rec();
    bus_wr(A_TX, 32'h0000_00A5, 3'b010);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_pop_latency: got tx=%b expected 1", tx); end
    busy_n = 0;
    a = A_ST; mode = 3'b010;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (rd[0]) busy_n++;
    end
    rec_en = 1'b0;
    checks++;
    if (first_zero() !== 2) begin errors++; $display("FAIL single_start: got %0d expected 2", first_zero()); end
    bq.push_back(8'hA5); dq.push_back(3);
    d = wave_diff(bq, dq);
    checks++;
    if (d !== 0) begin errors++; $display("FAIL single_wave: got %0d bad samples expected 0", d); end
    checks++;
    if (busy_n !== 40) begin errors++; $display("FAIL single_busy: got %0d expected 40", busy_n); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", irq); end
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL single_status: got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0] bq [$];
    int dq [$];
    logic [7:0] b;
    int d;
    bus_wr(A_DV, 32'd0, 3'b010);
    start_rec();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) begin bq.push_back(b); dq.push_back(0); end
      bus_wr(A_TX, {24'd0, b}, 3'b010);
    end
    // One byte in flight, eight queued, the tenth dropped.
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h8B) begin errors++; $display("FAIL ovf_status: got %h expected %h", v, 32'h8B); end
    bus_wr(A_ST, 32'h8, 3'b010);
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h83) begin errors++; $display("FAIL ovf_clear: got %h expected %h", v, 32'h83); end
    // First frame ends now: the pop frees a slot for this write.
    b = 8'($urandom);
    bq.push_back(b); dq.push_back(0);
    bus_wr(A_TX, {24'd0, b}, 3'b010);
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h83) begin errors++; $display("FAIL full_push_pop: got %h expected %h", v, 32'h83); end
    cycles(120);
    rec_en = 1'b0;
    d = wave_diff(bq, dq);
    checks++;
    if (d !== 0) begin errors++; $display("FAIL ovf_wave: got %0d bad samples expected 0", d); end
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL ovf_final: got %h expected %h", v, 32'h4); end
  endtask

  task automatic test_read_modes();
    logic [31:0] v, exp;
    logic [15:0] m;
    logic [2:0] md;
    logic [2:0] rmodes [5];
    logic [31:0] addr;
    rmodes[0] = 3'b000; rmodes[1] = 3'b001; rmodes[2] = 3'b010; rmodes[3] = 3'b100; rmodes[4] = 3'b101;
    bus_wr(A_DV, 32'h8081, 3'b010);
    bus_rd(A_DV, 3'b000, v); checks++;
    if (v !== 32'hFFFF_FF81) begin errors++; $display("FAIL lb: got %h expected %h", v, 32'hFFFF_FF81); end
    bus_rd(A_DV, 3'b100, v); checks++;
    if (v !== 32'h0000_0081) begin errors++; $display("FAIL lbu: got %h expected %h", v, 32'h81); end
    bus_rd(A_DV, 3'b001, v); checks++;
    if (v !== 32'hFFFF_8081) begin errors++; $display("FAIL lh: got %h expected %h", v, 32'hFFFF_8081); end
    bus_rd(A_DV, 3'b101, v); checks++;
    if (v !== 32'h0000_8081) begin errors++; $display("FAIL lhu: got %h expected %h", v, 32'h8081); end
    m = 16'h8081;
    for (int i = 0; i < 12; i++) begin
      wd = $urandom;
      addr = A_DV | 32'($urandom_range(0, 3));
      md = 3'($urandom_range(0, 2));
      if (md == 3'b000) begin
        if (addr[0]) m = {wd[7:0], m[7:0]};
        else         m = {m[15:8], wd[7:0]};
      end else begin
        m = wd[15:0];
      end
      bus_wr(addr, wd, md);
      md = rmodes[$urandom_range(0, 4)];
      case (md)
        3'b000:  exp = 32'($signed(m[7:0]));
        3'b001:  exp = 32'($signed(m));
        3'b100:  exp = 32'(m[7:0]);
        3'b101:  exp = 32'(m);
        default: exp = 32'(m);
      endcase
      bus_rd(A_DV | 32'($urandom_range(0, 3)), md, v);
      checks++;
      if (v !== exp) begin errors++; $display("FAIL rand_div_rd: got %h expected %h mode %b", v, exp, md); end
    end
    bus_rd(A_TX, 3'b010, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL txdata_rd: got %h expected 0", v); end
    bus_rd(BASE + 32'hC, 3'b010, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL off3_rd: got %h expected 0", v); end
    bus_rd(32'h1234_5678, 3'b010, v); checks++;
    if (v !== 32'h0 || hit !== 1'b0) begin errors++; $display("FAIL miss_rd: got rd=%h hit=%b expected 0/0", v, hit); end
    bus_rd(BASE + 32'h7, 3'b010, v); checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL hit: got %b expected 1", hit); end
  endtask

  task automatic test_div_change();
    logic [7:0] bq [$];
    int dq [$];
    int d;
    bus_wr(A_DV, 32'd1, 3'b010);
    bq.push_back(8'($urandom)); dq.push_back(1);
    bq.push_back(8'($urandom)); dq.push_back(4);
    start_rec();
    bus_wr(A_TX, {24'd0, bq[0]}, 3'b000);
    bus_wr(A_TX, {24'd0, bq[1]}, 3'b001);
    cycles(4);
    bus_wr(A_DV, 32'd4, 3'b010);
    cycles(90);
    rec_en = 1'b0;
    d = wave_diff(bq, dq);
    checks++;
    if (d !== 0) begin errors++; $display("FAIL div_change_wave: got %0d bad samples expected 0", d); end
  endtask

  task automatic test_random();
    logic [7:0] bq [$];
    int dq [$];
    int dv, n, d;
    logic [31:0] v;
    for (int it = 0; it < 4; it++) begin
      bq.delete(); dq.delete();
      dv = $urandom_range(0, 3);
      n = $urandom_range(1, 5);
      bus_wr(A_DV, 32'(dv), 3'b010);
      start_rec();
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom)); dq.push_back(dv);
        bus_wr(A_TX, {$urandom, bq[i]} >> 0, 3'($urandom_range(0, 2)));
      end
      cycles(n * 10 * (dv + 1) + 20);
      rec_en = 1'b0;
      d = wave_diff(bq, dq);
      checks++;
      if (d !== 0) begin errors++; $display("FAIL rand_wave: got %0d bad samples expected 0 (div %0d n %0d)", d, dv, n); end
      bus_rd(A_ST, 3'b010, v);
      checks++;
      if (v !== 32'h4 || irq !== 1'b1) begin errors++; $display("FAIL rand_idle: got %h irq %b expected 4 irq 1", v, irq); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bq [$];
    int dq [$];
    int d;
    logic [31:0] v;
    bus_wr(A_DV, 32'd3, 3'b010);
    for (int i = 0; i < 3; i++) bus_wr(A_TX, $urandom, 3'b010);
    cycles(16);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    bus_rd(A_ST, 3'b010, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL midreset_status: got %h expected %h", v, 32'h4); end
    bus_rd(A_DV, 3'b010, v);
    checks++;
    if (v !== 32'd867) begin errors++; $display("FAIL midreset_div: got %0d expected 867", v); end
    start_rec();
    cycles(80);
    rec_en = 1'b0;
    d = wave_diff(bq, dq);
    checks++;
    if (d !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d low samples expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_read_modes();
    test_div_change();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
